// File: rtl/stepper_move_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : stepper_move_ctrl
//  Description : Move scheduler for the 4-phase stepper driver. Accepts a
//                move command (direction, step count, step period), issues
//                one-cycle step pulses at a fixed rate, tracks the signed
//                absolute position and reports completion or abort.
//  Revision    : 1.0 - initial release
// ============================================================================
module stepper_move_ctrl #(
    parameter int STEP_W  = 16,
    parameter int PER_W   = 20,
    parameter int MIN_PER = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_dir,
    input  logic [STEP_W-1:0]   cmd_steps,
    input  logic [PER_W-1:0]    cmd_period,
    input  logic                abort,
    output logic                step_en,
    output logic                step_dir,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic signed [31:0]  pos
);

    localparam logic [PER_W-1:0]  c_min_per  = PER_W'(MIN_PER);
    localparam logic [PER_W-1:0]  c_per_one  = PER_W'(1);
    localparam logic [STEP_W-1:0] c_step_one = STEP_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [STEP_W-1:0]    r_remaining;
    logic [PER_W-1:0]     r_timer;
    logic [PER_W-1:0]     r_per_m1;
    logic                 r_step_en;
    logic                 r_step_dir;
    logic                 r_aborted;
    logic signed [31:0]   r_pos;

    logic                 w_accept;
    logic [PER_W-1:0]     w_per_eff;
    logic                 w_last_step;
    logic                 w_tick;

    // Requests shorter than the motor can follow are stretched to MIN_PER.
    assign w_per_eff   = (cmd_period < c_min_per) ? c_min_per : cmd_period;
    assign cmd_ready   = (r_state == S_IDLE) && rst;
    assign w_accept    = cmd_valid && cmd_ready;
    // The pulse currently on step_en is the final one of the move.
    assign w_last_step = r_step_en && (r_remaining == c_step_one);
    // Timer value 1 means the next cycle carries a step pulse; an abort in
    // this cycle suppresses it.
    assign w_tick      = (r_state == S_RUN) && !abort && (r_timer == c_per_one);

    assign step_en  = r_step_en;
    assign step_dir = r_step_dir;
    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_DONE);
    assign aborted  = r_aborted;
    assign pos      = r_pos;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: zero-length moves go straight to DONE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (cmd_steps == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (abort || w_last_step) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Move datapath: command latch, step timer, step counter and position.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_remaining <= '0;
            r_timer     <= '0;
            r_per_m1    <= '0;
            r_step_en   <= 1'b0;
            r_step_dir  <= 1'b0;
            r_aborted   <= 1'b0;
            r_pos       <= '0;
        end else begin
            r_step_en <= w_tick;
            if (r_step_en) begin
                r_pos <= r_step_dir ? (r_pos + 32'sd1) : (r_pos - 32'sd1);
            end
            if (w_accept) begin
                r_step_dir  <= cmd_dir;
                r_remaining <= cmd_steps;
                r_per_m1    <= w_per_eff - c_per_one;
                r_timer     <= w_per_eff - c_per_one;
                r_aborted   <= 1'b0;
            end else if (r_state == S_RUN) begin
                if (abort) begin
                    r_aborted <= 1'b1;
                end
                // Reload on every step so the period never accumulates drift.
                if (r_step_en) begin
                    r_remaining <= r_remaining - c_step_one;
                    r_timer     <= r_per_m1;
                end else begin
                    r_timer     <= r_timer - c_per_one;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stepper_move_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stepper_move_ctrl
//  Description : Self-checking bench for stepper_move_ctrl. Moves come from
//                a vector table; expected step cycles are queued per move and
//                popped as step pulses appear.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stepper_move_ctrl;

    localparam int STEP_W  = 16;
    localparam int PER_W   = 20;
    localparam int MIN_PER = 4;

    logic               clk;
    logic               rst;
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_dir;
    logic [STEP_W-1:0]  cmd_steps;
    logic [PER_W-1:0]   cmd_period;
    logic               abort;
    logic               step_en;
    logic               step_dir;
    logic               busy;
    logic               done;
    logic               aborted;
    logic signed [31:0] pos;

    int n_checks = 0;
    int n_fail   = 0;
    longint exp_pos = 0;
    int exp_q[$];

    typedef struct {
        logic dir;
        int   steps;
        int   period;
        int   abort_at;   // cycle in which abort is high, -1 = none
        int   exp_done;   // cycle carrying the done pulse
        logic exp_ab;
        int   exp_delta;  // position change of this move
    } vec_t;

    stepper_move_ctrl #(
        .STEP_W (STEP_W),
        .PER_W  (PER_W),
        .MIN_PER(MIN_PER)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_steps (cmd_steps),
        .cmd_period(cmd_period),
        .abort     (abort),
        .step_en   (step_en),
        .step_dir  (step_dir),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .pos       (pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Called at a negedge in an idle cycle (cycle 0 of the move).
    task automatic run_move(input vec_t v);
        int p;
        int done_cnt;
        int done_at;
        int ctl_err;
        int e;
        chk("ready_before_move", longint'(cmd_ready), 1);
        p = (v.period < MIN_PER) ? MIN_PER : v.period;
        exp_q.delete();
        for (int k = 1; k <= v.steps; k++) begin
            if (v.abort_at < 0 || k * p <= v.abort_at) exp_q.push_back(k * p);
        end
        cmd_valid  = 1'b1;
        cmd_dir    = v.dir;
        cmd_steps  = STEP_W'(v.steps);
        cmd_period = PER_W'(v.period);
        @(negedge clk);
        // Inputs need not hold after accept.
        cmd_valid  = 1'b0;
        cmd_dir    = ~v.dir;
        cmd_steps  = STEP_W'($urandom);
        cmd_period = PER_W'($urandom);
        done_cnt = 0;
        done_at  = -1;
        ctl_err  = 0;
        for (int cyc = 1; cyc <= v.exp_done + 1; cyc++) begin
            abort = (cyc == v.abort_at);
            if (step_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("step_extra_cycle", cyc, -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("step_cycle", cyc, e);
                end
            end
            if (busy !== (cyc < v.exp_done)) ctl_err++;
            if (cmd_ready !== (cyc == v.exp_done + 1)) ctl_err++;
            if (busy === 1'b1 && step_dir !== v.dir) ctl_err++;
            if (done === 1'b1) begin
                done_cnt++;
                done_at = cyc;
            end
            @(negedge clk);
        end
        abort = 1'b0;
        exp_pos = exp_pos + v.exp_delta;
        chk("steps_missing", exp_q.size(), 0);
        chk("done_pulses", done_cnt, 1);
        chk("done_cycle", done_at, v.exp_done);
        chk("aborted", longint'(aborted), longint'(v.exp_ab));
        chk("pos", longint'(pos), exp_pos);
        chk("busy_ready_dir_errors", ctl_err, 0);
    endtask

    vec_t vecs[9];
    int   err;

    initial begin
        vecs[0] = '{1'b1,  3,    5, -1,   16, 1'b0,  3};
        vecs[1] = '{1'b1,  0,    9, -1,    1, 1'b0,  0};
        vecs[2] = '{1'b0,  2,    1, -1,    9, 1'b0, -2};
        vecs[3] = '{1'b1, 10,    8, 20,   21, 1'b1,  2};
        vecs[4] = '{1'b0,  1,    4, -1,    5, 1'b0, -1};
        vecs[5] = '{1'b1,  2,    4,  8,    9, 1'b1,  2};
        vecs[6] = '{1'b0,  3,    0, -1,   13, 1'b0, -3};
        vecs[7] = '{1'b1,  2,    6,  3,    4, 1'b1,  0};
        vecs[8] = '{1'b1,  1, 1000, -1, 1001, 1'b0,  1};

        rst        = 1'b0;
        cmd_valid  = 1'b0;
        cmd_dir    = 1'b0;
        cmd_steps  = '0;
        cmd_period = '0;
        abort      = 1'b0;

        // Reset held for three cycles, outputs idle throughout.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            err = 0;
            if (step_en !== 1'b0 || step_dir !== 1'b0 || busy !== 1'b0) err++;
            if (done !== 1'b0 || aborted !== 1'b0 || cmd_ready !== 1'b0) err++;
            chk("reset_outputs", err, 0);
            chk("reset_pos", longint'(pos), 0);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", longint'(cmd_ready), 1);

        for (int i = 0; i < 9; i++) begin
            run_move(vecs[i]);
        end

        // cmd_valid held through a 5x4 move, reset asserted in cycle 7.
        cmd_valid  = 1'b1;
        cmd_dir    = 1'b1;
        cmd_steps  = STEP_W'(5);
        cmd_period = PER_W'(4);
        @(negedge clk);
        err = 0;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            if (busy !== 1'b1 || cmd_ready !== 1'b0 || done !== 1'b0) err++;
            if (step_en !== (cyc == 4)) err++;
            if (cyc == 7) rst = 1'b0;
            @(negedge clk);
        end
        chk("held_valid_move", err, 0);
        for (int i = 0; i < 2; i++) begin
            err = 0;
            if (step_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0) err++;
            if (cmd_ready !== 1'b0 || aborted !== 1'b0) err++;
            chk("midmove_reset_outputs", err, 0);
            chk("midmove_reset_pos", longint'(pos), 0);
            cmd_valid = 1'b0;
            @(negedge clk);
        end
        rst = 1'b1;
        exp_pos = 0;
        @(negedge clk);
        chk("ready_after_midmove_reset", longint'(cmd_ready), 1);
        run_move(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
